// File: rtl/riscv_checkpoint_checker.sv
// -----------------------------------------------------------------------------
// riscv_checkpoint_checker
//
// Retirement checker that sits behind the RISC-V core. It walks an ordered
// table of (instruction count, expected answer) checkpoints and reports
// PASS/FAIL, diagnostics and the run length. Because the result is held in
// registers, the same block works in simulation and on an FPGA with the
// status driving LEDs.
//
// The checkpoint table is a packed parameter vector. It is a constant ROM,
// so no file and no memory initialisation are needed, and an unset table
// reads as all zeros. Word 2i holds the expected NUM_INST of entry i and
// word 2i+1 holds the expected OUTPUT_PORT. Word w occupies bits
// [32w+31:32w].
//
// Ports:
//   CLK          clock, rising edge
//   RSTn         asynchronous active-low reset
//   NUM_INST     retired-instruction count from the core
//   OUTPUT_PORT  core result port
//   HALT         core halt indication
//   CHK_CLR      synchronous restart of the checker, highest priority
//   CYCLE        run-cycle counter; freezes in the final state
//   TEST_IDX     index of the next checkpoint (= checkpoints passed)
//   DONE         PASS | FAIL
//   PASS, FAIL   final state flags
//   FAIL_CODE    0 none, 1 mismatch, 2 skipped, 3 early halt, 4 timeout
//   FAIL_GOT     OUTPUT_PORT at the failure (0 for early halt and timeout)
//   FAIL_EXP     expected answer at TEST_IDX when the failure occurred
//
// State   | meaning
// --------+------------------------------------------------
// ST_RUN  | checking active, CYCLE counting
// ST_PASS | all checkpoints matched and HALT seen (sticky)
// ST_FAIL | failure latched with diagnostics (sticky)
// -----------------------------------------------------------------------------
module riscv_checkpoint_checker #(
   parameter int                         NUM_TEST   = 17,
   parameter int                         IDX_W      = 5,
   parameter logic [2*NUM_TEST*32-1:0]   TABLE_INIT = '0,
   parameter int                         TIMEOUT    = 100000
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [31:0]       NUM_INST,
   input  logic [31:0]       OUTPUT_PORT,
   input  logic              HALT,
   input  logic              CHK_CLR,
   output logic [31:0]       CYCLE,
   output logic [IDX_W-1:0]  TEST_IDX,
   output logic              DONE,
   output logic              PASS,
   output logic              FAIL,
   output logic [2:0]        FAIL_CODE,
   output logic [31:0]       FAIL_GOT,
   output logic [31:0]       FAIL_EXP
);

   typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEST);
   localparam logic [31:0]      CYC_LAST = 32'(TIMEOUT - 1);

   state_t            state;
   logic              active;
   logic              hit;
   logic              ok;
   logic              bad_val;
   logic              skip;
   logic [IDX_W-1:0]  sel;
   logic [IDX_W-1:0]  idx_post;
   logic [IDX_W-1:0]  sel_post;
   logic [31:0]       e_num;
   logic [31:0]       e_ans;
   logic [31:0]       e_ans_post;

   function automatic logic [31:0] word_at(input int w);
      return TABLE_INIT[w*32 +: 32];
   endfunction

   // Only entry TEST_IDX is ever looked at. The index is clamped so the ROM
   // is never addressed past its end once every checkpoint has matched.
   always_comb begin
      active     = (TEST_IDX < LAST_IDX);
      sel        = active ? TEST_IDX : '0;
      e_num      = active ? word_at(2*int'(sel))     : '0;
      e_ans      = active ? word_at(2*int'(sel) + 1) : '0;
      hit        = active && (NUM_INST == e_num);
      ok         = hit && (OUTPUT_PORT == e_ans);
      bad_val    = hit && !ok;
      skip       = active && (NUM_INST > e_num);
      idx_post   = ok ? TEST_IDX + IDX_W'(1) : TEST_IDX;
      // The reported expectation uses the index as it stands after this
      // edge's compare, which is the TEST_IDX the failure is shown with.
      sel_post   = (idx_post < LAST_IDX) ? idx_post : '0;
      e_ans_post = (idx_post < LAST_IDX) ? word_at(2*int'(sel_post) + 1) : '0;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= ST_RUN;
         CYCLE     <= '0;
         TEST_IDX  <= '0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         FAIL      <= 1'b0;
         FAIL_CODE <= 3'd0;
         FAIL_GOT  <= '0;
         FAIL_EXP  <= '0;
      end else if (CHK_CLR) begin
         state     <= ST_RUN;
         CYCLE     <= '0;
         TEST_IDX  <= '0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         FAIL      <= 1'b0;
         FAIL_CODE <= 3'd0;
         FAIL_GOT  <= '0;
         FAIL_EXP  <= '0;
      end else if (state == ST_RUN) begin
         TEST_IDX <= idx_post;
         // The compare result outranks HALT, and HALT outranks the timeout.
         // CYCLE only advances while the run continues, so its value at the
         // terminating edge is the value that stays visible.
         if (bad_val || skip) begin
            state     <= ST_FAIL;
            DONE      <= 1'b1;
            FAIL      <= 1'b1;
            FAIL_CODE <= bad_val ? 3'd1 : 3'd2;
            FAIL_GOT  <= OUTPUT_PORT;
            FAIL_EXP  <= e_ans_post;
         end else if (HALT) begin
            DONE <= 1'b1;
            if (idx_post == LAST_IDX) begin
               state <= ST_PASS;
               PASS  <= 1'b1;
            end else begin
               state     <= ST_FAIL;
               FAIL      <= 1'b1;
               FAIL_CODE <= 3'd3;
               FAIL_GOT  <= '0;
               FAIL_EXP  <= e_ans_post;
            end
         end else if (CYCLE == CYC_LAST) begin
            state     <= ST_FAIL;
            DONE      <= 1'b1;
            FAIL      <= 1'b1;
            FAIL_CODE <= 3'd4;
            FAIL_GOT  <= '0;
            FAIL_EXP  <= e_ans_post;
         end else begin
            CYCLE <= CYCLE + 32'd1;
         end
      end
   end

endmodule
